branch_resolve_queue: RTL
=========================

// Module: branch_resolve_queue
// PURPOSE
//  Resolve-side partner of the global branch predictor. Holds one in-order record per in-flight predicted branch.
//  Records are pushed from decode and popped when the branch resolves in memory stage.
//  On each pop the block compares prediction against outcome and issues a one-cycle PHT update.
//  On a wrong prediction it also issues a mispredict redirect and clears every younger record.
// PARAMETERS
//  PHT_DEPTH    6   width of PHT index carried per record
//  QUEUE_DEPTH  4   record slots; power of two, >=2
//  CNT_W        log2(QUEUE_DEPTH)+1 (derived localparam)   occupancy counter width
// PORTS
//  clk               in   1          clock, rising edge
//  rst               in   1          synchronous active-high reset
//  push_valid        in   1          decode-stage branch leaving D (branchD & ~stallD & ~flushD)
//  push_pc           in   32         PC of that branch
//  push_pred_take    in   1          predicted direction
//  push_pred_target  in   32         target used by fetch when predicted taken
//  push_pht_index    in   PHT_DEPTH  PHT index the prediction was read from
//  push_ready        out  1          record will be accepted this cycle
//  resolve_valid     in   1          oldest branch resolves (branchM)
//  resolve_take      in   1          actual direction (actual_takeM)
//  resolve_target    in   32         actual computed target
//  update_valid      out  1          PHT/GHR update pulse
//  update_take       out  1          outcome to train with
//  update_pht_index  out  PHT_DEPTH  PHT entry to train
//  mispredict        out  1          redirect pulse; drives flushD/flushE
//  redirect_pc       out  32         fetch restart address, valid with mispredict
//  count             out  CNT_W      records held
//  empty / full      out  1 / 1      count==0 / count==QUEUE_DEPTH
//  err_underflow     out  1          sticky: resolve_valid seen while empty
//  stat_resolved     out  32         resolved-branch counter (see CONFIGURATION)
//  stat_mispred      out  32         mispredict counter (see CONFIGURATION)
// BEHAVIOUR
//  Storage: circular buffer with head/tail pointers wrapping modulo QUEUE_DEPTH, plus count register.
//  Reset: pointers and count 0; update_valid, mispredict and err_underflow 0; redirect_pc 0; update_* 0; stats 0.
//   Reset wins over all same-cycle events, including mid-flight records, which are discarded.
//  push_ready = ~full | (resolve_valid & ~empty & ~wrong), where wrong is computed combinationally from head vs resolve inputs.
//   push_valid & ~push_ready: record dropped, no state change.
//  Resolve, when resolve_valid & ~empty: the head record pops.
//   wrong = (pred_take != resolve_take) | (pred_take & resolve_take & pred_target != resolve_target).
//  Outputs are registered, valid exactly the cycle after resolve; all pulses last 1 cycle:
//   update_valid=1, update_take=resolve_take, update_pht_index=head.pht_index.
//   mispredict=wrong; redirect_pc = resolve_take ? resolve_target : head.pc+8 (32-bit wrap, delay slot).
//   When wrong is 0, mispredict=0 and redirect_pc holds its old value.
//  Mispredict recovery, same edge as the pop: count<=0, tail<=head+1, head<=head+1. A same-cycle push is ignored.
//  Simultaneous non-wrong pop and push: both occur, count unchanged; allowed even when full.
//  resolve_valid & empty: no pop, no update pulse, err_underflow<=1 (cleared only by rst).
//  resolve_valid low: update_valid=0, mispredict=0 next cycle.
// CONFIGURATION
//  BRQ_STATS_EN defined: stat_resolved increments on every pop; stat_mispred increments on every pop with wrong=1.
//   Both counters saturate at 32'hFFFF_FFFF and reset to 0.
//  BRQ_STATS_EN undefined: counters not built; stat_resolved and stat_mispred tied to 0.
// TESTING
//  rst, then push pc=0x100 pred_take=0 idx=5; resolve take=0 -> next cycle update_valid=1 idx=5 take=0, mispredict=0, empty=1.
//  push pc=0x200 pred_take=1 tgt=0x300; resolve take=0 -> mispredict=1, redirect_pc=0x208.
//  push pc=0x200 pred_take=1 tgt=0x300; resolve take=1 tgt=0x340 -> mispredict=1, redirect_pc=0x340.
//  fill 4 records (full=1); next push alone dropped (count stays 4); push with correct resolve -> count stays 4, FIFO order kept.
//  3 records queued, head mispredicts with same-cycle push -> count=0, empty=1, pushed record discarded.
//  resolve_valid while empty -> err_underflow=1, no update pulse.
//  With BRQ_STATS_EN: 10 resolves, 3 wrong -> stat_resolved=10, stat_mispred=3. Without it: both 0.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch record queue that trains the PHT and redirects fetch on mispredict
// Optional macro BRQ_STATS_EN builds saturating resolve/mispredict counters; otherwise the stat outputs are 0.
module branch_resolve_queue #(
  parameter int PHT_DEPTH   = 6,
  parameter int QUEUE_DEPTH = 4,
  localparam int CNT_W      = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid,
  input  logic [31:0]          push_pc,
  input  logic                 push_pred_take,
  input  logic [31:0]          push_pred_target,
  input  logic [PHT_DEPTH-1:0] push_pht_index,
  output logic                 push_ready,
  input  logic                 resolve_valid,
  input  logic                 resolve_take,
  input  logic [31:0]          resolve_target,
  output logic                 update_valid,
  output logic                 update_take,
  output logic [PHT_DEPTH-1:0] update_pht_index,
  output logic                 mispredict,
  output logic [31:0]          redirect_pc,
  output logic [CNT_W-1:0]     count,
  output logic                 empty,
  output logic                 full,
  output logic                 err_underflow,
  output logic [31:0]          stat_resolved,
  output logic [31:0]          stat_mispred
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  logic [31:0]          pc_q   [QUEUE_DEPTH];
  logic [31:0]          pc_d   [QUEUE_DEPTH];
  logic                 take_q [QUEUE_DEPTH];
  logic                 take_d [QUEUE_DEPTH];
  logic [31:0]          tgt_q  [QUEUE_DEPTH];
  logic [31:0]          tgt_d  [QUEUE_DEPTH];
  logic [PHT_DEPTH-1:0] idx_q  [QUEUE_DEPTH];
  logic [PHT_DEPTH-1:0] idx_d  [QUEUE_DEPTH];

  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 update_valid_q, update_valid_d;
  logic                 update_take_q, update_take_d;
  logic [PHT_DEPTH-1:0] update_idx_q, update_idx_d;
  logic                 mispredict_q, mispredict_d;
  logic [31:0]          redirect_q, redirect_d;
  logic                 err_q, err_d;

  logic wrong, do_pop, flush, do_push;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(QUEUE_DEPTH));

  // Direction mismatch, or both taken but to different targets.
  assign wrong = (take_q[head_q] != resolve_take) |
                 (take_q[head_q] & resolve_take & (tgt_q[head_q] != resolve_target));
  assign do_pop     = resolve_valid & ~empty;
  assign flush      = do_pop & wrong;
  assign push_ready = ~full | (resolve_valid & ~empty & ~wrong);
  assign do_push    = push_valid & push_ready & ~flush;

  always_comb begin
    pc_d           = pc_q;
    take_d         = take_q;
    tgt_d          = tgt_q;
    idx_d          = idx_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    update_valid_d = do_pop;
    update_take_d  = do_pop ? resolve_take : update_take_q;
    update_idx_d   = do_pop ? idx_q[head_q] : update_idx_q;
    mispredict_d   = flush;
    redirect_d     = redirect_q;
    err_d          = err_q | (resolve_valid & empty);
    if (flush) begin
      // Younger records are wrong-path; collapse the queue just past the resolved head.
      head_d     = head_q + 1'b1;
      tail_d     = head_q + 1'b1;
      count_d    = '0;
      redirect_d = resolve_take ? resolve_target : pc_q[head_q] + 32'd8;
    end else begin
      if (do_push) begin
        pc_d[tail_q]   = push_pc;
        take_d[tail_q] = push_pred_take;
        tgt_d[tail_q]  = push_pred_target;
        idx_d[tail_q]  = push_pht_index;
        tail_d         = tail_q + 1'b1;
      end
      if (do_pop) head_d = head_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    take_q <= take_d;
    tgt_q  <= tgt_d;
    idx_q  <= idx_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      update_valid_q <= 1'b0;
      update_take_q  <= 1'b0;
      update_idx_q   <= '0;
      mispredict_q   <= 1'b0;
      redirect_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      update_valid_q <= update_valid_d;
      update_take_q  <= update_take_d;
      update_idx_q   <= update_idx_d;
      mispredict_q   <= mispredict_d;
      redirect_q     <= redirect_d;
      err_q          <= err_d;
    end
  end

  assign count            = count_q;
  assign update_valid     = update_valid_q;
  assign update_take      = update_take_q;
  assign update_pht_index = update_idx_q;
  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_q;
  assign err_underflow    = err_q;

`ifdef BRQ_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d, stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_resolved_d = stat_resolved_q;
    stat_mispred_d  = stat_mispred_q;
    if (do_pop && stat_resolved_q != 32'hFFFF_FFFF) stat_resolved_d = stat_resolved_q + 32'd1;
    if (flush && stat_mispred_q != 32'hFFFF_FFFF)   stat_mispred_d  = stat_mispred_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_resolved_q <= stat_resolved_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`else
  assign stat_resolved = 32'd0;
  assign stat_mispred  = 32'd0;
`endif
endmodule
